// File: rtl/dt_skeleton_extract.sv
// Skeleton extraction over a finished distance map: marks interior ridge pixels
// (nonzero, >= all 8 neighbours), packs them 16 per word and tracks count / max.
module dt_skeleton_extract #(
    parameter int IMG_W  = 128,
    parameter int WORD_W = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         res_rd,
    output logic [2*$clog2(IMG_W)-1:0]                   res_addr,
    input  logic [7:0]                                   res_di,
    output logic                                         ske_wr,
    output logic [2*$clog2(IMG_W)-$clog2(WORD_W)-1:0]    ske_addr,
    output logic [WORD_W-1:0]                            ske_do,
    output logic [2*$clog2(IMG_W)-1:0]                   ske_cnt,
    output logic [7:0]                                   max_dist
);
    localparam int AW = $clog2(IMG_W);
    localparam int PW = 2 * AW;
    localparam int WB = $clog2(WORD_W);
    localparam logic [AW-1:0] C_LAST     = AW'(IMG_W - 1);
    localparam logic [AW-1:0] C_N1_MAX   = AW'(IMG_W - 3);
    localparam logic [AW-1:0] C_N2_MAX   = AW'(IMG_W - 4);
    localparam logic [WB-1:0] C_PRE_WRAP = WB'(WORD_W - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_BRD, S_RD_C, S_EV_C, S_RD_N, S_EV_N, S_WR, S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_busy, r_done, r_rd, r_wr, r_spec;
    logic [PW-1:0]         r_addr, r_cur, r_cnt;
    logic [PW-WB-1:0]      r_ske_addr;
    logic [WORD_W-1:0]     r_ske_do, r_word;
    logic [7:0]            r_max, r_c;
    logic [2:0]            r_idx;

    logic [AW-1:0]         w_row, w_col;
    logic [PW-1:0]         w_cur_p1, w_cur_p2;
    logic                  w_row_int, w_n1_int, w_n2_int, w_wrap, w_last;
    logic                  w_shift, w_stream, w_bit, w_adv, w_nb_fail;
    logic [WORD_W-1:0]     w_word_nx;

    function automatic logic [PW-1:0] nb_addr(input logic [PW-1:0] ctr, input logic [2:0] idx);
        case (idx)
            3'd0:    nb_addr = ctr - PW'(IMG_W + 1);
            3'd1:    nb_addr = ctr - PW'(IMG_W);
            3'd2:    nb_addr = ctr - PW'(IMG_W - 1);
            3'd3:    nb_addr = ctr - PW'(1);
            3'd4:    nb_addr = ctr + PW'(1);
            3'd5:    nb_addr = ctr + PW'(IMG_W - 1);
            3'd6:    nb_addr = ctr + PW'(IMG_W);
            default: nb_addr = ctr + PW'(IMG_W + 1);
        endcase
    endfunction

    assign w_row     = r_cur[PW-1:AW];
    assign w_col     = r_cur[AW-1:0];
    assign w_cur_p1  = r_cur + PW'(1);
    assign w_cur_p2  = r_cur + PW'(2);
    assign w_row_int = (w_row != '0) && (w_row != C_LAST);
    assign w_n1_int  = w_row_int && (w_col <= C_N1_MAX);
    assign w_n2_int  = w_row_int && (w_col <= C_N2_MAX);
    assign w_wrap    = &w_col[WB-1:0];
    assign w_last    = &r_cur;
    assign w_nb_fail = (res_di > r_c);
    assign w_word_nx = {r_word[WORD_W-2:0], w_bit};
    assign w_adv     = w_shift && !w_stream;

    always_comb begin
        w_shift  = 1'b0;
        w_stream = 1'b0;
        w_bit    = 1'b0;
        case (r_state)
            S_BRD:  w_shift = 1'b1;
            S_EV_C: begin
                w_shift  = (res_di == 8'd0);
                w_stream = (res_di == 8'd0) && r_spec;
            end
            S_EV_N: begin
                w_shift = w_nb_fail || (r_idx == 3'd7);
                w_bit   = !w_nb_fail;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_spec     <= 1'b0;
            r_addr     <= '0;
            r_cur      <= '0;
            r_cnt      <= '0;
            r_ske_addr <= '0;
            r_ske_do   <= '0;
            r_word     <= '0;
            r_max      <= '0;
            r_c        <= '0;
            r_idx      <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur   <= '0;
                        r_cnt   <= '0;
                        r_max   <= '0;
                        r_word  <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rd    <= 1'b0;
                        r_state <= S_BRD;
                    end
                end
                // The next center is fetched ahead so a run of zero pixels streams at one per cycle.
                S_RD_C: begin
                    if (w_n1_int && !w_wrap) begin
                        r_addr <= w_cur_p1;
                        r_rd   <= 1'b1;
                        r_spec <= 1'b1;
                    end else begin
                        r_rd   <= 1'b0;
                        r_spec <= 1'b0;
                    end
                    r_state <= S_EV_C;
                end
                S_EV_C: begin
                    r_c <= res_di;
                    if (res_di > r_max) r_max <= res_di;
                    if (res_di != 8'd0) begin
                        r_addr  <= nb_addr(r_cur, 3'd0);
                        r_rd    <= 1'b1;
                        r_state <= S_RD_N;
                    end else if (r_spec) begin
                        r_cur <= w_cur_p1;
                        if (w_n2_int && (w_col[WB-1:0] != C_PRE_WRAP)) begin
                            r_addr <= w_cur_p2;
                            r_rd   <= 1'b1;
                            r_spec <= 1'b1;
                        end else begin
                            r_rd   <= 1'b0;
                            r_spec <= 1'b0;
                        end
                    end
                end
                S_RD_N: begin
                    r_addr  <= nb_addr(r_cur, 3'd1);
                    r_idx   <= '0;
                    r_state <= S_EV_N;
                end
                S_EV_N: begin
                    if (!w_shift) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx <= 3'd5) r_addr <= nb_addr(r_cur, r_idx + 3'd2);
                        else               r_rd   <= 1'b0;
                    end
                end
                S_WR: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cur <= w_cur_p1;
                        if (w_n1_int) begin
                            r_addr  <= w_cur_p1;
                            r_rd    <= 1'b1;
                            r_state <= S_RD_C;
                        end else begin
                            r_state <= S_BRD;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_shift) begin
                r_word <= w_word_nx;
                if (w_bit) r_cnt <= r_cnt + PW'(1);
            end
            if (w_adv) begin
                if (w_wrap) begin
                    r_wr       <= 1'b1;
                    r_ske_addr <= {w_row, w_col[AW-1:WB]};
                    r_ske_do   <= w_word_nx;
                    r_rd       <= 1'b0;
                    r_state    <= S_WR;
                end else begin
                    r_cur <= w_cur_p1;
                    if (w_n1_int) begin
                        r_addr  <= w_cur_p1;
                        r_rd    <= 1'b1;
                        r_state <= S_RD_C;
                    end else begin
                        r_rd    <= 1'b0;
                        r_state <= S_BRD;
                    end
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign res_rd   = r_rd;
    assign res_addr = r_addr;
    assign ske_wr   = r_wr;
    assign ske_addr = r_ske_addr;
    assign ske_do   = r_ske_do;
    assign ske_cnt  = r_cnt;
    assign max_dist = r_max;
endmodule

// File: tb/tb_dt_skeleton_extract.sv
// Bench for dt_skeleton_extract: behavioural distance memory, reference skeleton
// model feeding a write scoreboard, plus reset/restart robustness scenarios.
module tb_dt_skeleton_extract;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, res_rd, ske_wr;
    logic [13:0] res_addr, ske_cnt;
    logic [7:0]  res_di = 8'd0;
    logic [9:0]  ske_addr;
    logic [15:0] ske_do;
    logic [7:0]  max_dist;

    dt_skeleton_extract #(.IMG_W(128), .WORD_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
        .ske_wr(ske_wr), .ske_addr(ske_addr), .ske_do(ske_do),
        .ske_cnt(ske_cnt), .max_dist(max_dist)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:16383];
    always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned wr_count;
    int unsigned forbid_reads;
    int unsigned exp_cnt;
    logic [7:0]  exp_max;
    logic [15:0] got [0:1023];
    bit          scan_ok;

    function automatic logic [7:0] px(input int r, input int c);
        return mem[14'(r * 128 + c)];
    endfunction

    function automatic bit is_skel(input int r, input int c);
        logic [7:0] v;
        if (r < 1 || r > 126 || c < 1 || c > 126) return 1'b0;
        v = px(r, c);
        if (v == 8'd0) return 1'b0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if ((dr != 0 || dc != 0) && px(r + dr, c + dc) > v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_map();
        for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    endtask

    task automatic build_expected();
        wr_t         e;
        logic [15:0] word;
        sb_q.delete();
        exp_cnt = 0;
        exp_max = 8'd0;
        for (int r = 0; r < 128; r++) begin
            for (int w = 0; w < 8; w++) begin
                word = '0;
                for (int b = 0; b < 16; b++) begin
                    if (is_skel(r, w * 16 + b)) begin
                        word[15 - b] = 1'b1;
                        exp_cnt++;
                    end
                end
                e.addr = 10'(r * 8 + w);
                e.data = word;
                sb_q.push_back(e);
            end
        end
        for (int r = 1; r < 127; r++)
            for (int c = 1; c < 127; c++)
                if (px(r, c) > exp_max) exp_max = px(r, c);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Samples every negedge until done (or a write quota); scoreboards each ske write.
    task automatic run_scan(input int unsigned limit, input int unsigned pulse_at,
                            input int unsigned stop_writes, output bit ok);
        wr_t e;
        ok = 1'b0;
        wr_count = 0;
        forbid_reads = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            if (res_rd && (res_addr == 14'd5 || res_addr == 14'd16383)) forbid_reads++;
            if (ske_wr) begin
                wr_count++;
                got[ske_addr] = ske_do;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL ske_write unexpected: addr=%0d data=%h, queue empty", ske_addr, ske_do);
                end else begin
                    e = sb_q.pop_front();
                    if (ske_addr !== e.addr || ske_do !== e.data) begin
                        errors++;
                        $display("FAIL ske_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 ske_addr, ske_do, e.addr, e.data);
                    end
                end
            end
            if (done || wr_count >= stop_writes) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, res_rd, ske_wr} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/rd/wr=%b expected 0000", {busy, done, res_rd, ske_wr});
        end
        checks++;
        if (res_addr !== 14'd0 || ske_addr !== 10'd0 || ske_do !== 16'd0) begin
            errors++;
            $display("FAIL reset_bus: res_addr=%0d ske_addr=%0d ske_do=%h expected 0", res_addr, ske_addr, ske_do);
        end
        checks++;
        if (ske_cnt !== 14'd0 || max_dist !== 8'd0) begin
            errors++;
            $display("FAIL reset_stats: cnt=%0d max=%0d expected 0", ske_cnt, max_dist);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) begin start = 1'b0; reset = 1'b0; end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: busy=%b expected 0", busy);
        end
    endtask

    task automatic check_scan_end(input string name);
        checks++;
        if (!scan_ok) begin
            errors++;
            $display("FAIL %s_timeout: done not seen, writes=%0d", name, wr_count);
        end
        checks++;
        if (wr_count !== 1024) begin
            errors++;
            $display("FAIL %s_write_count: got %0d expected 1024", name, wr_count);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: %0d expected writes left", name, sb_q.size());
        end
        checks++;
        if (ske_cnt !== 14'(exp_cnt) || max_dist !== exp_max) begin
            errors++;
            $display("FAIL %s_stats: cnt=%0d max=%0d expected cnt=%0d max=%0d",
                     name, ske_cnt, max_dist, exp_cnt, exp_max);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: busy=%b done=%b expected 0/1", name, busy, done);
        end
    endtask

    task automatic test_start_ack();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_ack: busy=%b done=%b expected 1/0", busy, done);
        end
    endtask

    task automatic test_zero_border();
        clear_map();
        mem[5]     = 8'd9;
        mem[16383] = 8'd200;
        build_expected();
        pulse_start();
        test_start_ack();
        run_scan(30000, 2000, 2000, scan_ok);
        check_scan_end("zero_border");
        checks++;
        if (ske_cnt !== 14'd0 || max_dist !== 8'd0) begin
            errors++;
            $display("FAIL zero_border_literal: cnt=%0d max=%0d expected 0/0", ske_cnt, max_dist);
        end
        checks++;
        if (forbid_reads != 0) begin
            errors++;
            $display("FAIL border_reads: %0d reads of border pixels, expected 0", forbid_reads);
        end
    endtask

    task automatic test_single_plateau();
        clear_map();
        mem[64 * 128 + 64] = 8'd5;
        for (int r = 9; r <= 11; r++)
            for (int c = 19; c <= 22; c++) mem[r * 128 + c] = 8'd1;
        mem[10 * 128 + 20] = 8'd3;
        mem[10 * 128 + 21] = 8'd3;
        build_expected();
        pulse_start();
        test_start_ack();
        run_scan(30000, 99999, 2000, scan_ok);
        check_scan_end("single_plateau");
        checks++;
        if (got[516] !== 16'h8000) begin
            errors++;
            $display("FAIL single_word: ske[516]=%h expected 8000", got[516]);
        end
        checks++;
        if (got[81] !== 16'h0C00) begin
            errors++;
            $display("FAIL plateau_word: ske[81]=%h expected 0c00", got[81]);
        end
        checks++;
        if (ske_cnt !== 14'd3 || max_dist !== 8'd5) begin
            errors++;
            $display("FAIL single_plateau_literal: cnt=%0d max=%0d expected 3/5", ske_cnt, max_dist);
        end
    endtask

    task automatic load_square();
        int d;
        clear_map();
        for (int r = 60; r <= 64; r++) begin
            for (int c = 60; c <= 64; c++) begin
                d = r - 60;
                if (64 - r < d) d = 64 - r;
                if (c - 60 < d) d = c - 60;
                if (64 - c < d) d = 64 - c;
                mem[r * 128 + c] = 8'(d + 1);
            end
        end
    endtask

    task automatic test_reset_midscan();
        int unsigned wc;
        load_square();
        build_expected();
        pulse_start();
        run_scan(30000, 99999, 300, scan_ok);
        checks++;
        if (!scan_ok) begin
            errors++;
            $display("FAIL midscan_timeout: writes=%0d expected 300", wr_count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, res_rd, ske_wr} !== 4'b0 || res_addr !== 14'd0 || ske_addr !== 10'd0 ||
            ske_do !== 16'd0 || ske_cnt !== 14'd0 || max_dist !== 8'd0) begin
            errors++;
            $display("FAIL midscan_reset: ctrl=%b res_addr=%0d ske_addr=%0d do=%h cnt=%0d max=%0d expected all 0",
                     {busy, done, res_rd, ske_wr}, res_addr, ske_addr, ske_do, ske_cnt, max_dist);
        end
        @(negedge clk) reset = 1'b0;
        wc = 0;
        repeat (100) begin
            @(negedge clk);
            if (ske_wr) wc++;
        end
        checks++;
        if (wc != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midscan_quiet: writes after reset=%0d busy=%b expected 0/0", wc, busy);
        end
    endtask

    task automatic test_restart_square();
        build_expected();
        pulse_start();
        test_start_ack();
        run_scan(30000, 99999, 2000, scan_ok);
        check_scan_end("square");
        checks++;
        if (got[499] !== 16'h0002) begin
            errors++;
            $display("FAIL square_word: ske[499]=%h expected 0002", got[499]);
        end
        checks++;
        if (ske_cnt !== 14'd1 || max_dist !== 8'd3) begin
            errors++;
            $display("FAIL square_literal: cnt=%0d max=%0d expected 1/3", ske_cnt, max_dist);
        end
    endtask

    initial begin
        test_reset();
        test_zero_border();
        test_single_plateau();
        test_reset_midscan();
        test_restart_square();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
